ad_frame_writer: RTL and testbench
==================================

AD_FRAME_WRITER -- requirements
Module: ad_frame_writer

Interface
REQ-001 Parameter DATA_NUM, default 2048, samples per frame per channel.
REQ-002 Parameter AD_WIDTH, default 14, ADC sample width.
REQ-003 Parameter RST_CYCLES, default 8, length of the FIFO reset pulse in clocks.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset; these are the first two ports.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  synchronous active-low reset.
REQ-007 ad_data0  in  AD_WIDTH  channel-0 ADC sample.
REQ-008 ad_data1  in  AD_WIDTH  channel-1 ADC sample.
REQ-009 ad_valid  in  1  sample strobe, both channels valid.
REQ-010 full0  in  1  FIFO-0 full.
REQ-011 full1  in  1  FIFO-1 full.
REQ-012 wr_rst_busy  in  1  OR of both FIFOs' reset-busy flags.
REQ-013 frame_done  in  1  one-cycle pulse from the FFT path's output tlast.
REQ-014 din0  out  AD_WIDTH  FIFO-0 write data.
REQ-015 din1  out  AD_WIDTH  FIFO-1 write data.
REQ-016 wr_en  out  1  common write enable for both FIFOs.
REQ-017 fifo_rst  out  1  active-high FIFO reset.
REQ-018 ad_fifo_ready  out  1  a full frame is buffered and the reader may start.
REQ-019 overflow  out  1  sticky sample-drop flag.
REQ-020 sample_cnt  out  $clog2(DATA_NUM)+1  samples written in the current frame.

Function
REQ-021 States: FLUSH, WAIT_RDY, CAPTURE, HOLD.
REQ-022 FLUSH: fifo_rst=1 for exactly RST_CYCLES clocks, then go to WAIT_RDY.
REQ-023 WAIT_RDY: stay while wr_rst_busy=1; on wr_rst_busy=0, go to CAPTURE and set sample_cnt=0.
REQ-024 CAPTURE: on each ad_valid, register din0/din1 and pulse wr_en one clock later; sample_cnt increments with each wr_en.
REQ-025 The sample that makes sample_cnt equal DATA_NUM SHALL be the last write; the next state is HOLD.
REQ-026 HOLD: wr_en=0, ad_fifo_ready=1, ad_valid ignored; on frame_done go to FLUSH with ad_fifo_ready=0 in the same transition.
REQ-027 frame_done outside HOLD SHALL be ignored.
REQ-028 If ad_valid arrives in CAPTURE while full0 or full1 is 1, the sample SHALL be dropped, overflow set, and the state go to FLUSH (frame aborted).
REQ-029 overflow SHALL clear only on reset.
REQ-030 wr_en SHALL never assert in FLUSH, WAIT_RDY or HOLD, nor while wr_rst_busy=1.
REQ-031 ad_valid asserted on consecutive clocks SHALL be accepted at full rate with no gaps.

Reset
REQ-032 With rst=0 at a clock edge, the state SHALL become FLUSH with the pulse counter cleared; din0, din1, wr_en, ad_fifo_ready, overflow and sample_cnt SHALL be 0, and fifo_rst SHALL be 1.
REQ-033 A reset during CAPTURE or HOLD SHALL abort the frame and restart from FLUSH.

Configuration
REQ-034 With macro AD_OFFSET_BIN_EN defined, din SHALL be the ADC sample with its MSB inverted (offset binary to two's complement).
REQ-035 Without AD_OFFSET_BIN_EN, din SHALL pass the ADC sample unchanged.

Structure
REQ-036 The state encoding and the default values for DATA_NUM and AD_WIDTH SHALL live in the shared package ad_pkg.
REQ-037 The reset-pulse timer SHALL be a sub-module, fifo_rst_gen.

Verification
REQ-038 Reset, then release; wr_rst_busy high for 20 clocks -> fifo_rst high for 8 clocks, no wr_en until busy falls.
REQ-039 DATA_NUM=16, ad_valid continuous with ad_data0 = 0..15 -> exactly 16 wr_en pulses, din0 = 0..15, ad_fifo_ready=1, sample_cnt=16.
REQ-040 In HOLD, 100 further ad_valid strobes -> no wr_en; then a frame_done pulse -> ad_fifo_ready=0 and fifo_rst high on the next clock.
REQ-041 full0=1 at sample 5 -> sample dropped, overflow=1, fifo_rst pulse follows, capture restarts at sample_cnt=0.
REQ-042 AD_OFFSET_BIN_EN defined, ad_data0=14'h2000 -> din0=14'h0000; ad_data0=14'h1FFF -> din0=14'h3FFF.
REQ-043 Reset asserted at sample 7 of CAPTURE -> all outputs at reset values the next clock, with a full FLUSH sequence before the next write.

Source files
------------

// File: rtl/ad_pkg.sv
// Shared definitions for the ADC frame writer: FSM encoding and default sizing.
package ad_pkg;

    localparam int DATA_NUM_DEFAULT = 2048;
    localparam int AD_WIDTH_DEFAULT = 14;

    localparam logic [1:0] ST_FLUSH    = 2'd0;
    localparam logic [1:0] ST_WAIT_RDY = 2'd1;
    localparam logic [1:0] ST_CAPTURE  = 2'd2;
    localparam logic [1:0] ST_HOLD     = 2'd3;

endpackage

// File: rtl/fifo_rst_gen.sv
// Times the FIFO reset pulse: done rises on the last of RST_CYCLES clocks with en held.
module fifo_rst_gen #(
    parameter int RST_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic done
);

    localparam int TW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    logic [TW-1:0] cnt;

    assign done = en && (cnt == TW'(RST_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst || !en)
            cnt <= '0;
        else if (!done)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/ad_frame_writer.sv
// Writes one frame of dual-channel ADC samples into a FIFO pair, then holds until the
// FFT path signals frame_done. Define AD_OFFSET_BIN_EN to convert offset binary to two's complement.
module ad_frame_writer
    import ad_pkg::*;
#(
    parameter int DATA_NUM   = DATA_NUM_DEFAULT,
    parameter int AD_WIDTH   = AD_WIDTH_DEFAULT,
    parameter int RST_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AD_WIDTH-1:0]         ad_data0,
    input  logic [AD_WIDTH-1:0]         ad_data1,
    input  logic                        ad_valid,
    input  logic                        full0,
    input  logic                        full1,
    input  logic                        wr_rst_busy,
    input  logic                        frame_done,
    output logic [AD_WIDTH-1:0]         din0,
    output logic [AD_WIDTH-1:0]         din1,
    output logic                        wr_en,
    output logic                        fifo_rst,
    output logic                        ad_fifo_ready,
    output logic                        overflow,
    output logic [$clog2(DATA_NUM):0]   sample_cnt
);

    localparam int CW = $clog2(DATA_NUM) + 1;

    logic [1:0]          state;
    logic                flush_done;
    logic                frame_full;
    logic                take;
    logic                drop;
    logic [AD_WIDTH-1:0] smp0;
    logic [AD_WIDTH-1:0] smp1;

`ifdef AD_OFFSET_BIN_EN
    assign smp0 = ad_data0 ^ {1'b1, {(AD_WIDTH-1){1'b0}}};
    assign smp1 = ad_data1 ^ {1'b1, {(AD_WIDTH-1){1'b0}}};
`else
    assign smp0 = ad_data0;
    assign smp1 = ad_data1;
`endif

    // Stay in CAPTURE for the cycle the last write is on the bus, so wr_en never overlaps HOLD.
    assign frame_full = (sample_cnt == CW'(DATA_NUM));
    assign take       = (state == ST_CAPTURE) && ad_valid && !full0 && !full1
                        && !wr_rst_busy && !frame_full;
    assign drop       = (state == ST_CAPTURE) && ad_valid && (full0 || full1) && !frame_full;

    assign fifo_rst      = (state == ST_FLUSH);
    assign ad_fifo_ready = (state == ST_HOLD);

    fifo_rst_gen #(
        .RST_CYCLES (RST_CYCLES)
    ) u_rst_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_FLUSH),
        .done (flush_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_FLUSH;
            din0       <= '0;
            din1       <= '0;
            wr_en      <= 1'b0;
            overflow   <= 1'b0;
            sample_cnt <= '0;
        end else begin
            wr_en <= take;
            if (take) begin
                din0       <= smp0;
                din1       <= smp1;
                sample_cnt <= sample_cnt + 1'b1;
            end
            case (state)
                ST_FLUSH:
                    if (flush_done)
                        state <= ST_WAIT_RDY;
                ST_WAIT_RDY:
                    if (!wr_rst_busy) begin
                        state      <= ST_CAPTURE;
                        sample_cnt <= '0;
                    end
                ST_CAPTURE:
                    if (drop) begin
                        state    <= ST_FLUSH;
                        overflow <= 1'b1;
                    end else if (frame_full) begin
                        state <= ST_HOLD;
                    end
                ST_HOLD:
                    if (frame_done)
                        state <= ST_FLUSH;
                default:
                    state <= ST_FLUSH;
            endcase
        end
    end

endmodule

// File: tb/tb_ad_frame_writer.sv
// Scoreboard bench for ad_frame_writer with DATA_NUM=16; honours AD_OFFSET_BIN_EN.
module tb_ad_frame_writer;

    localparam int DN = 16;
    localparam int AW = 14;

    typedef struct {
        logic [AW-1:0] d0;
        logic [AW-1:0] d1;
    } smp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] ad_data0 = '0;
    logic [AW-1:0] ad_data1 = '0;
    logic          ad_valid = 1'b0;
    logic          full0 = 1'b0;
    logic          full1 = 1'b0;
    logic          wr_rst_busy = 1'b0;
    logic          frame_done = 1'b0;
    logic [AW-1:0] din0;
    logic [AW-1:0] din1;
    logic          wr_en;
    logic          fifo_rst;
    logic          ad_fifo_ready;
    logic          overflow;
    logic [4:0]    sample_cnt;

    ad_frame_writer #(
        .DATA_NUM   (DN),
        .AD_WIDTH   (AW),
        .RST_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ad_data0      (ad_data0),
        .ad_data1      (ad_data1),
        .ad_valid      (ad_valid),
        .full0         (full0),
        .full1         (full1),
        .wr_rst_busy   (wr_rst_busy),
        .frame_done    (frame_done),
        .din0          (din0),
        .din1          (din1),
        .wr_en         (wr_en),
        .fifo_rst      (fifo_rst),
        .ad_fifo_ready (ad_fifo_ready),
        .overflow      (overflow),
        .sample_cnt    (sample_cnt)
    );

    always #5 clk = ~clk;

    smp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   wr_cnt = 0;
    int   fr_cnt = 0;
    int   bad_wr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [AW-1:0] xf(input logic [AW-1:0] d);
`ifdef AD_OFFSET_BIN_EN
        return d ^ 14'h2000;
`else
        return d;
`endif
    endfunction

    // One clock; outputs are observed 1ns after the edge, then the caller drives.
    task automatic tick();
        smp_t e;
        @(posedge clk);
        #1;
        if (fifo_rst)
            fr_cnt++;
        if (wr_en) begin
            wr_cnt++;
            if (fifo_rst || ad_fifo_ready || wr_rst_busy)
                bad_wr++;
            if (sb.size() == 0) begin
                chk("spurious_wr", wr_en, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("din0", din0, e.d0);
                chk("din1", din1, e.d1);
            end
        end
    endtask

    task automatic send(input logic [AW-1:0] d0, input logic [AW-1:0] d1, input bit expect_wr);
        smp_t e;
        ad_valid = 1'b1;
        ad_data0 = d0;
        ad_data1 = d1;
        if (expect_wr) begin
            e.d0 = xf(d0);
            e.d1 = xf(d1);
            sb.push_back(e);
        end
        tick();
    endtask

    // Bounded wait for the flush pulse to end, then one clock into CAPTURE.
    task automatic start_frame(input string tag);
        int n = 0;
        while (fifo_rst && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_flush_end"}, fifo_rst, 1'b0);
        chk({tag, "_flush_len"}, fr_cnt, 8);
        tick();
        chk({tag, "_cnt0"}, sample_cnt, 0);
    endtask

    task automatic check_hold(input string tag);
        tick();
        chk({tag, "_ready"}, ad_fifo_ready, 1'b1);
        chk({tag, "_cnt"}, sample_cnt, DN);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;

        // Reset state
        rst = 1'b0;
        repeat (2) tick();
        fr_cnt = 0;
        tick();
        chk("rst_din0", din0, 0);
        chk("rst_din1", din1, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_fifo_rst", fifo_rst, 1);
        chk("rst_ready", ad_fifo_ready, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cnt", sample_cnt, 0);

        // Release with FIFO reset-busy held for 20 clocks
        rst = 1'b1;
        wr_rst_busy = 1'b1;
        ad_valid = 1'b1;
        repeat (20) tick();
        chk("busy_flush_len", fr_cnt, 8);
        chk("busy_no_wr", wr_cnt, 0);
        chk("busy_fifo_rst_low", fifo_rst, 0);
        ad_valid = 1'b0;
        wr_rst_busy = 1'b0;
        tick();

        // Frame 1: ramp 0..15 at full rate, then 100 strobes in HOLD
        w0 = wr_cnt;
        for (int i = 0; i < DN; i++)
            send(AW'(i), AW'(1000 + i), 1'b1);
        for (int i = 0; i < 100; i++)
            send(AW'(500 + i), AW'(i), 1'b0);
        chk("f1_wr_count", wr_cnt - w0, DN);
        chk("f1_ready", ad_fifo_ready, 1);
        chk("f1_cnt", sample_cnt, DN);
        chk("f1_sb_empty", sb.size(), 0);
        ad_valid = 1'b0;

        // frame_done leaves HOLD
        frame_done = 1'b1;
        fr_cnt = 0;
        tick();
        frame_done = 1'b0;
        chk("fd_ready", ad_fifo_ready, 0);
        chk("fd_fifo_rst", fifo_rst, 1);

        // Frame 2: overflow at sample 5
        start_frame("f2");
        for (int i = 0; i < 5; i++)
            send(AW'(200 + i), AW'(300 + i), 1'b1);
        full0 = 1'b1;
        fr_cnt = 0;
        send(AW'(205), AW'(305), 1'b0);
        full0 = 1'b0;
        ad_valid = 1'b0;
        chk("ovf_flag", overflow, 1);
        chk("ovf_fifo_rst", fifo_rst, 1);
        chk("ovf_wr_en", wr_en, 0);
        chk("ovf_sb_empty", sb.size(), 0);

        // Frame 3: restart after overflow; stray frame_done mid-capture; offset-binary edges
        start_frame("f3");
        w0 = wr_cnt;
        for (int i = 0; i < DN; i++) begin
            frame_done = (i == 3);
            if (i == DN - 2)
                send(14'h2000, 14'h1FFF, 1'b1);
            else if (i == DN - 1)
                send(14'h1FFF, 14'h2000, 1'b1);
            else
                send(AW'($urandom), AW'($urandom), 1'b1);
        end
        frame_done = 1'b0;
        ad_valid = 1'b0;
        check_hold("f3");
        chk("f3_wr_count", wr_cnt - w0, DN);
        chk("f3_ovf_sticky", overflow, 1);

        // Frame 4: reset at sample 7
        frame_done = 1'b1;
        fr_cnt = 0;
        tick();
        frame_done = 1'b0;
        start_frame("f4");
        for (int i = 0; i < 7; i++)
            send(AW'($urandom), AW'($urandom), 1'b1);
        rst = 1'b0;
        fr_cnt = 0;
        send(AW'(77), AW'(88), 1'b0);
        chk("mrst_din0", din0, 0);
        chk("mrst_din1", din1, 0);
        chk("mrst_wr_en", wr_en, 0);
        chk("mrst_fifo_rst", fifo_rst, 1);
        chk("mrst_ready", ad_fifo_ready, 0);
        chk("mrst_overflow", overflow, 0);
        chk("mrst_cnt", sample_cnt, 0);
        rst = 1'b1;
        ad_valid = 1'b0;
        w0 = wr_cnt;
        start_frame("f5");
        chk("f5_no_wr_in_flush", wr_cnt - w0, 0);
        for (int i = 0; i < 3; i++)
            send(AW'(40 + i), AW'(50 + i), 1'b1);
        ad_valid = 1'b0;
        tick();
        chk("f5_cnt", sample_cnt, 3);
        chk("f5_sb_empty", sb.size(), 0);
        chk("illegal_wr", bad_wr, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
